// File: rtl/abs_diff_pkg.sv
// Shared types and arithmetic helpers for the abs-diff statistics core.
// Helpers take wide operands so one definition serves any parameterisation.
package abs_diff_pkg;

   typedef enum logic [1:0] {
      MODE_ABS    = 2'd0,
      MODE_BIN    = 2'd1,
      MODE_PASS_A = 2'd2,
      MODE_PASS_B = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } ctrl_st_e;

   localparam int ARG_W = 32;  // symbols up to 31 bits, leaving room for zero-extension
   localparam int SAT_W = 64;

   function automatic logic [ARG_W-1:0] abs_diff(input logic [ARG_W-1:0] a,
                                                 input logic [ARG_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // Saturating add; w is the real counter width (1..64).
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] count,
                                                input logic [SAT_W-1:0] increment,
                                                input int               w);
      logic [SAT_W:0] sum;
      logic [SAT_W:0] max;
      sum = {1'b0, count} + {1'b0, increment};
      max = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
      return (sum > max) ? max[SAT_W-1:0] : sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/abs_diff_lane.sv
// One symbol: absolute difference, mode select and the "changed" compare flag.
module abs_diff_lane
   import abs_diff_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   input  mode_e           mode_i,
   input  logic [BITS-1:0] thr_i,
   output logic [BITS-1:0] res_o,
   output logic            chg_o
);

   logic [BITS-1:0] d;

   assign d     = BITS'(abs_diff(ARG_W'(a_i), ARG_W'(b_i)));
   assign chg_o = d > thr_i;

   always_comb begin
      res_o = d;
      case (mode_i)
         MODE_ABS:    res_o = d;
         MODE_BIN:    res_o = chg_o ? '1 : '0;
         MODE_PASS_A: res_o = a_i;
         MODE_PASS_B: res_o = b_i;
         default:     res_o = d;
      endcase
   end

endmodule

// File: rtl/abs_diff_stats_core.sv
// Per-symbol A/B operation through a PIPE_STAGES-deep pipeline, in-order
// control-packet forwarding, and per-frame beat / changed-symbol statistics.
module abs_diff_stats_core
   import abs_diff_pkg::*;
#(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 3,
   parameter int PIPE_STAGES      = 2,
   parameter int CNT_WIDTH        = 32
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        stall_in,
   input  logic                                        stall_out,
   output logic                                        read,
   output logic                                        write,
   input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_A_in,
   input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_B_in,
   input  logic                                        end_of_video,
   input  logic [15:0]                                 width_in,
   input  logic [15:0]                                 height_in,
   input  logic [3:0]                                  interlaced_in,
   input  logic                                        vip_ctrl_valid_in,
   input  logic [1:0]                                  mode,
   input  logic [BITS_PER_SYMBOL-1:0]                  threshold,
   output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
   output logic                                        end_of_video_out,
   output logic [15:0]                                 width_out,
   output logic [15:0]                                 height_out,
   output logic [3:0]                                  interlaced_out,
   output logic                                        vip_ctrl_valid_out,
   output logic [CNT_WIDTH-1:0]                        stat_beats,
   output logic [CNT_WIDTH-1:0]                        stat_changed,
   output logic                                        stat_valid
);

   localparam int BPS = BITS_PER_SYMBOL;
   localparam int SPB = SYMBOLS_PER_BEAT;
   localparam int DW  = BPS * SPB;
   localparam int PW  = $clog2(SPB + 1);
   localparam int LS  = PIPE_STAGES - 1;

   logic [LS:0]            vld_q;
   logic [LS:0][DW-1:0]    data_q;
   logic [LS:0]            eov_q;
   logic [LS:0][PW-1:0]    pop_q;

   logic                   frame_start_q;
   mode_e                  mode_q;
   logic [BPS-1:0]         thr_q;

   ctrl_st_e               ctrl_q;
   logic [15:0]            w_q, h_q;
   logic [3:0]             il_q;

   logic [CNT_WIDTH-1:0]   beat_cnt_q, chg_cnt_q, beat_cnt_d, chg_cnt_d;

   logic                   adv;
   mode_e                  eff_mode;
   logic [BPS-1:0]         eff_thr;
   logic [SPB-1:0][BPS-1:0] res_w;
   logic [SPB-1:0]         chg_w;
   logic [PW-1:0]          pop_w;

   assign adv   = ~stall_out;
   assign read  = ~stall_in & ~stall_out & (ctrl_q == ST_IDLE);
   assign write = vld_q[LS] & adv;

   // The first beat of a frame sees the live mode/threshold it is about to latch.
   assign eff_mode = frame_start_q ? mode_e'(mode) : mode_q;
   assign eff_thr  = frame_start_q ? threshold : thr_q;

   for (genvar s = 0; s < SPB; s++) begin : g_lane
      abs_diff_lane #(.BITS(BPS)) u_lane (
         .a_i    (data_A_in[s*BPS +: BPS]),
         .b_i    (data_B_in[s*BPS +: BPS]),
         .mode_i (eff_mode),
         .thr_i  (eff_thr),
         .res_o  (res_w[s]),
         .chg_o  (chg_w[s])
      );
   end

   always_comb begin
      pop_w = '0;
      for (int s = 0; s < SPB; s++) pop_w = pop_w + PW'(chg_w[s]);
   end

   // Stage 0 holds the finished result; later stages only delay it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q  <= '0;
         data_q <= '0;
         eov_q  <= '0;
         pop_q  <= '0;
      end else if (adv) begin
         vld_q[0]  <= read;
         data_q[0] <= res_w;
         eov_q[0]  <= end_of_video & read;
         pop_q[0]  <= pop_w;
         for (int k = 1; k < PIPE_STAGES; k++) begin
            vld_q[k]  <= vld_q[k-1];
            data_q[k] <= data_q[k-1];
            eov_q[k]  <= eov_q[k-1];
            pop_q[k]  <= pop_q[k-1];
         end
      end
   end

   assign data_out         = data_q[LS];
   assign end_of_video_out = eov_q[LS];

   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_start_q <= 1'b1;
         mode_q        <= MODE_ABS;
         thr_q         <= '0;
      end else if (read) begin
         if (frame_start_q) begin
            mode_q <= mode_e'(mode);
            thr_q  <= threshold;
         end
         frame_start_q <= end_of_video;
      end
   end

   always_comb begin
      beat_cnt_d = CNT_WIDTH'(sat_inc(SAT_W'(beat_cnt_q), SAT_W'(1), CNT_WIDTH));
      chg_cnt_d  = CNT_WIDTH'(sat_inc(SAT_W'(chg_cnt_q), SAT_W'(pop_q[LS]), CNT_WIDTH));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         beat_cnt_q   <= '0;
         chg_cnt_q    <= '0;
         stat_beats   <= '0;
         stat_changed <= '0;
         stat_valid   <= 1'b0;
      end else begin
         stat_valid <= 1'b0;
         if (write && eov_q[LS]) begin
            stat_beats   <= beat_cnt_d;
            stat_changed <= chg_cnt_d;
            stat_valid   <= 1'b1;
            beat_cnt_q   <= '0;
            chg_cnt_q    <= '0;
         end else if (write) begin
            beat_cnt_q <= beat_cnt_d;
            chg_cnt_q  <= chg_cnt_d;
         end
      end
   end

   // Control packet waits until every in-flight pixel has left the pipeline.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_q             <= ST_IDLE;
         w_q                <= '0;
         h_q                <= '0;
         il_q               <= '0;
         width_out          <= '0;
         height_out         <= '0;
         interlaced_out     <= '0;
         vip_ctrl_valid_out <= 1'b0;
      end else begin
         vip_ctrl_valid_out <= 1'b0;
         if (vip_ctrl_valid_in) begin
            w_q    <= width_in;
            h_q    <= height_in;
            il_q   <= interlaced_in;
            ctrl_q <= ST_PENDING;
         end else begin
            case (ctrl_q)
               ST_PENDING: if (vld_q == '0) begin
                  width_out          <= w_q;
                  height_out         <= h_q;
                  interlaced_out     <= il_q;
                  vip_ctrl_valid_out <= 1'b1;
                  ctrl_q             <= ST_IDLE;
               end
               default: ctrl_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_abs_diff_stats_core.sv
// Directed bench for abs_diff_stats_core (default parameters, PIPE_STAGES=2).
module tb_abs_diff_stats_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_in = 1'b1, stall_out = 1'b0;
   logic        read, write;
   logic [23:0] data_A_in = '0, data_B_in = '0;
   logic        end_of_video = 1'b0;
   logic [15:0] width_in = '0, height_in = '0;
   logic [3:0]  interlaced_in = '0;
   logic        vip_ctrl_valid_in = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [7:0]  threshold = '0;
   logic [23:0] data_out;
   logic        end_of_video_out;
   logic [15:0] width_out, height_out;
   logic [3:0]  interlaced_out;
   logic        vip_ctrl_valid_out;
   logic [31:0] stat_beats, stat_changed;
   logic        stat_valid;

   abs_diff_stats_core dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .stall_out(stall_out),
      .read(read), .write(write), .data_A_in(data_A_in), .data_B_in(data_B_in),
      .end_of_video(end_of_video), .width_in(width_in), .height_in(height_in),
      .interlaced_in(interlaced_in), .vip_ctrl_valid_in(vip_ctrl_valid_in),
      .mode(mode), .threshold(threshold), .data_out(data_out),
      .end_of_video_out(end_of_video_out), .width_out(width_out),
      .height_out(height_out), .interlaced_out(interlaced_out),
      .vip_ctrl_valid_out(vip_ctrl_valid_out), .stat_beats(stat_beats),
      .stat_changed(stat_changed), .stat_valid(stat_valid)
   );

   always #5 clk = ~clk;

   int          n_tests = 0, n_fail = 0;
   int          cyc = 0;
   logic [23:0] wr_data[$];
   logic        wr_eov[$];
   int          wr_cyc[$];
   int          rd_cyc[$];
   int          sv_cnt = 0, cv_cnt = 0, cv_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (read) rd_cyc.push_back(cyc);
      if (write) begin
         wr_data.push_back(data_out);
         wr_eov.push_back(end_of_video_out);
         wr_cyc.push_back(cyc);
      end
      if (stat_valid) sv_cnt++;
      if (vip_ctrl_valid_out) begin
         cv_cnt++;
         cv_cyc = cyc;
      end
   end

   function automatic logic [23:0] wd(input int i);
      return (i < wr_data.size()) ? wr_data[i] : 24'hxxxxxx;
   endfunction

   function automatic int wc(input int i);
      return (i < wr_cyc.size()) ? wr_cyc[i] : -100;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      wr_data.delete(); wr_eov.delete(); wr_cyc.delete(); rd_cyc.delete();
      sv_cnt = 0; cv_cnt = 0;
   endtask

   task automatic beat(input logic [23:0] a, input logic [23:0] b, input logic eov);
      data_A_in = a; data_B_in = b; end_of_video = eov; stall_in = 1'b0;
      step();
   endtask

   task automatic idle(input int n);
      stall_in = 1'b1; end_of_video = 1'b0;
      repeat (n) step();
   endtask

   task automatic test_reset();
      rst = 1'b0; stall_in = 1'b1;
      repeat (2) step();
      n_tests++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL reset_data_out got %h want 0", data_out); end
      n_tests++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b want 0", write); end
      n_tests++; if ({stat_valid, stat_beats, stat_changed} !== '0) begin n_fail++; $display("FAIL reset_stats got %b/%0d/%0d want 0", stat_valid, stat_beats, stat_changed); end
      n_tests++; if ({vip_ctrl_valid_out, width_out, height_out, interlaced_out} !== '0) begin n_fail++; $display("FAIL reset_ctrl got %b/%0d want 0", vip_ctrl_valid_out, width_out); end
      rst = 1'b1;
      step();
      clr();
   endtask

   task automatic test_abs();
      clr();
      mode = 2'd0; threshold = 8'h10;
      beat(24'h1080FF, 24'hF08000, 1'b1);
      idle(5);
      n_tests++; if (wr_data.size() !== 1) begin n_fail++; $display("FAIL abs_write_count got %0d want 1", wr_data.size()); end
      n_tests++; if (wd(0) !== 24'hE000FF) begin n_fail++; $display("FAIL abs_data got %h want e000ff", wd(0)); end
      n_tests++; if (wc(0) - rd_cyc[0] !== 2) begin n_fail++; $display("FAIL abs_latency got %0d want 2", wc(0) - rd_cyc[0]); end
      n_tests++; if (wr_eov.size() < 1 || wr_eov[0] !== 1'b1) begin n_fail++; $display("FAIL abs_eov_out got missing/0 want 1"); end
      n_tests++; if (stat_beats !== 32'd1 || stat_changed !== 32'd2 || sv_cnt !== 1) begin n_fail++; $display("FAIL abs_stats got %0d/%0d/%0d want 1/2/1", stat_beats, stat_changed, sv_cnt); end
   endtask

   task automatic test_bin();
      clr();
      mode = 2'd1; threshold = 8'h20;
      beat(24'h505050, 24'h401050, 1'b1);
      idle(5);
      n_tests++; if (wd(0) !== 24'h00FF00) begin n_fail++; $display("FAIL bin_data got %h want 00ff00", wd(0)); end
      n_tests++; if (stat_beats !== 32'd1 || stat_changed !== 32'd1) begin n_fail++; $display("FAIL bin_stats got %0d/%0d want 1/1", stat_beats, stat_changed); end
   endtask

   task automatic test_back_to_back();
      clr();
      mode = 2'd0; threshold = 8'h00;
      for (int i = 0; i < 4; i++) beat(24'h030303, 24'h000000, i == 3);
      mode = 2'd2; threshold = 8'hFF;
      idle(1);
      // this read coincides with the end-of-frame write of beat 4
      beat(24'h123456, 24'h000000, 1'b1);
      stall_in = 1'b1; end_of_video = 1'b0;
      n_tests++; if (stat_valid !== 1'b1 || stat_beats !== 32'd4 || stat_changed !== 32'd12) begin n_fail++; $display("FAIL frame_stats got %b/%0d/%0d want 1/4/12", stat_valid, stat_beats, stat_changed); end
      step();
      n_tests++; if (stat_valid !== 1'b0) begin n_fail++; $display("FAIL frame_pulse_width got %b want 0", stat_valid); end
      idle(5);
      n_tests++; if (wr_data.size() !== 5) begin n_fail++; $display("FAIL b2b_write_count got %0d want 5", wr_data.size()); end
      n_tests++; if (wd(3) !== 24'h030303 || wc(3) - wc(0) !== 3) begin n_fail++; $display("FAIL b2b_frame_beats got %h span %0d want 030303 span 3", wd(3), wc(3) - wc(0)); end
      n_tests++; if (wd(4) !== 24'h123456) begin n_fail++; $display("FAIL b2b_new_mode got %h want 123456", wd(4)); end
      n_tests++; if (stat_beats !== 32'd1 || stat_changed !== 32'd0 || sv_cnt !== 2) begin n_fail++; $display("FAIL b2b_new_stats got %0d/%0d/%0d want 1/0/2", stat_beats, stat_changed, sv_cnt); end
   endtask

   task automatic test_ctrl();
      clr();
      mode = 2'd0; threshold = 8'h00;
      beat(24'h111111, 24'h000000, 1'b0);
      vip_ctrl_valid_in = 1'b1; width_in = 16'd320; height_in = 16'd100; interlaced_in = 4'h1;
      beat(24'h222222, 24'h000000, 1'b1);
      width_in = 16'd640; height_in = 16'd480; interlaced_in = 4'h3;
      end_of_video = 1'b0; stall_in = 1'b0;
      #1;
      n_tests++; if (read !== 1'b0) begin n_fail++; $display("FAIL ctrl_read_blocked got %b want 0", read); end
      step();
      vip_ctrl_valid_in = 1'b0;
      idle(8);
      n_tests++; if (wr_data.size() !== 2 || wd(1) !== 24'h222222) begin n_fail++; $display("FAIL ctrl_beats got %0d/%h want 2/222222", wr_data.size(), wd(1)); end
      n_tests++; if (cv_cnt !== 1 || cv_cyc !== wc(1) + 2) begin n_fail++; $display("FAIL ctrl_pulse got %0d at %0d want 1 at %0d", cv_cnt, cv_cyc, wc(1) + 2); end
      n_tests++; if (width_out !== 16'd640 || height_out !== 16'd480 || interlaced_out !== 4'h3) begin n_fail++; $display("FAIL ctrl_fields got %0d/%0d/%h want 640/480/3", width_out, height_out, interlaced_out); end
      stall_in = 1'b0;
      #1;
      n_tests++; if (read !== 1'b1) begin n_fail++; $display("FAIL ctrl_read_resume got %b want 1", read); end
      stall_in = 1'b1;
   endtask

   task automatic test_stall();
      int          idx;
      logic [23:0] held;
      clr();
      mode = 2'd0; threshold = 8'h00;
      idx = 0; held = '0;
      step();
      for (int c = 0; c < 30; c++) begin
         stall_out = (c >= 4 && c < 9);
         if (idx < 6) begin
            stall_in = 1'b0; data_A_in = {3{8'(idx + 1)}}; data_B_in = '0; end_of_video = (idx == 5);
         end else begin
            stall_in = 1'b1; end_of_video = 1'b0;
         end
         #1;
         if (stall_out) begin
            n_tests++; if (write !== 1'b0) begin n_fail++; $display("FAIL stall_write c=%0d got %b want 0", c, write); end
            if (c == 4) held = data_out;
            else begin
               n_tests++; if (data_out !== held) begin n_fail++; $display("FAIL stall_hold c=%0d got %h want %h", c, data_out, held); end
            end
         end
         if (read) idx++;
         step();
      end
      stall_out = 1'b0; stall_in = 1'b1;
      n_tests++; if (wr_data.size() !== 6) begin n_fail++; $display("FAIL stall_count got %0d want 6", wr_data.size()); end
      for (int i = 0; i < 6; i++) begin
         n_tests++; if (wd(i) !== {3{8'(i + 1)}}) begin n_fail++; $display("FAIL stall_order i=%0d got %h want %h", i, wd(i), {3{8'(i + 1)}}); end
      end
      n_tests++; if (stat_beats !== 32'd6 || stat_changed !== 32'd18) begin n_fail++; $display("FAIL stall_stats got %0d/%0d want 6/18", stat_beats, stat_changed); end
   endtask

   task automatic test_mode_latch();
      clr();
      mode = 2'd0; threshold = 8'h00;
      beat(24'h102030, 24'h000010, 1'b0);
      mode = 2'd2;
      beat(24'h405060, 24'h100000, 1'b1);
      beat(24'hAABBCC, 24'h112233, 1'b1);
      idle(5);
      n_tests++; if (wd(0) !== 24'h102020 || wd(1) !== 24'h305060) begin n_fail++; $display("FAIL latch_frame got %h,%h want 102020,305060", wd(0), wd(1)); end
      n_tests++; if (wd(2) !== 24'hAABBCC) begin n_fail++; $display("FAIL latch_next got %h want aabbcc", wd(2)); end
   endtask

   task automatic test_reset_mid();
      clr();
      mode = 2'd2; threshold = 8'h00;
      beat(24'h0A0A0A, 24'h000000, 1'b0);
      rst = 1'b0; stall_in = 1'b1;
      repeat (2) step();
      n_tests++; if (wr_data.size() !== 0 || sv_cnt !== 0) begin n_fail++; $display("FAIL rstmid_flush got %0d writes %0d pulses want 0/0", wr_data.size(), sv_cnt); end
      n_tests++; if (data_out !== 24'h0 || stat_beats !== 32'd0) begin n_fail++; $display("FAIL rstmid_outputs got %h/%0d want 0/0", data_out, stat_beats); end
      rst = 1'b1;
      step();
      mode = 2'd1; threshold = 8'h00;
      beat(24'h010000, 24'h000000, 1'b1);
      idle(5);
      n_tests++; if (wd(0) !== 24'hFF0000) begin n_fail++; $display("FAIL rstmid_newframe got %h want ff0000", wd(0)); end
      n_tests++; if (stat_beats !== 32'd1 || stat_changed !== 32'd1) begin n_fail++; $display("FAIL rstmid_stats got %0d/%0d want 1/1", stat_beats, stat_changed); end
   endtask

   initial begin
      test_reset();
      test_abs();
      test_bin();
      test_back_to_back();
      test_ctrl();
      test_stall();
      test_mode_latch();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/abs_diff_stats_core.md
Name: abs_diff_stats_core

Overview:
- Parametrised successor to the two-input absolute-difference core, sitting between the two-input flow-control wrapper and the control-packet encoder.
- Per symbol, computes one of four selectable operations on paired beats A/B, through a configurable-depth pipeline.
- Forwards control-packet metadata without letting it overtake in-flight pixels.
- Accumulates per-frame beat and "changed symbol" statistics for the position-estimation software.

Parameters:
- BITS_PER_SYMBOL, 8, bits per colour symbol.
- SYMBOLS_PER_BEAT, 3, symbols per beat; data width DW = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT.
- PIPE_STAGES, 2, data pipeline depth (1..4).
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- stall_in  in  1  wrapper has no paired A/B beat available.
- stall_out  in  1  downstream cannot accept a beat.
- read  out  1  consume the current A/B beat.
- write  out  1  data_out is valid and being written.
- data_A_in  in  DW  beat from input A.
- data_B_in  in  DW  beat from input B.
- end_of_video  in  1  current input beat is the last beat of the frame.
- width_in  in  16  control-packet width.
- height_in  in  16  control-packet height.
- interlaced_in  in  4  control-packet interlace field.
- vip_ctrl_valid_in  in  1  one-cycle pulse; control fields are valid.
- mode  in  2  operation select: 0 |A-B|; 1 threshold binarise; 2 pass A; 3 pass B.
- threshold  in  BITS_PER_SYMBOL  threshold used by mode 1 and by the statistics.
- data_out  out  DW  result beat.
- end_of_video_out  out  1  aligned with write.
- width_out  out  16  forwarded control-packet width.
- height_out  out  16  forwarded control-packet height.
- interlaced_out  out  4  forwarded control-packet interlace field.
- vip_ctrl_valid_out  out  1  one-cycle pulse to the encoder.
- stat_beats  out  CNT_WIDTH  beats in the last completed frame.
- stat_changed  out  CNT_WIDTH  symbols with |A-B| > threshold in the last completed frame.
- stat_valid  out  1  one-cycle pulse when the stat_* outputs update.

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0, all pipeline valid bits 0, counters 0, pending-ctrl flag 0, frame_start flag 1.
- Advance enable: adv = ~stall_out. The whole pipeline freezes while stall_out=1.
- read = ~stall_in & ~stall_out & ~ctrl_pending (combinational).
- write = vld[PIPE_STAGES-1] & ~stall_out (combinational).
- data_out and end_of_video_out are registered from the last stage.
- Latency: a beat read in cycle t appears with write in cycle t+PIPE_STAGES when no stalls occur.
- Mode/threshold latch: mode and threshold are captured into mode_r/thr_r on the first read beat of a frame (frame_start=1), then held for the whole frame. frame_start is set again after a beat with end_of_video is read.
- Per-symbol arithmetic (unsigned, operands zero-extended by 1 bit):
  - d = |a-b|, width BITS_PER_SYMBOL, never wraps; e.g. a=0x10, b=0xF0 gives 0xE0.
  - Mode 1 output: all-ones if d > thr_r, else 0.
  - Mode 2 output: a. Mode 3 output: b.
- Stage 0 registers d and a/b together with the sideband signals; the remaining stages are pure delay.
- Statistics, updated on write:
  - beat_cnt += 1.
  - chg_cnt += popcount of symbols with d > thr_r, computed in every mode.
  - Both counters saturate at all-ones.
- On write with end_of_video_out=1: stat_beats and stat_changed take the including-this-beat values, stat_valid pulses, and both counters clear to 0 in the same cycle.
- Control forwarding:
  - On vip_ctrl_valid_in: latch width/height/interlaced and set ctrl_pending.
  - While ctrl_pending=1, read=0.
  - When ctrl_pending=1 and all vld bits are 0: drive the *_out fields, pulse vip_ctrl_valid_out for one cycle, clear ctrl_pending.
  - A second vip_ctrl_valid_in while pending overwrites the latched fields; only one pulse is produced.
  - vip_ctrl_valid_in and a read in the same cycle: the beat is accepted; pending takes effect from the next cycle.
- Simultaneous write of an end_of_video beat and a read of a new frame's first beat: statistics close the old frame, and the new beat latches new mode/threshold.
- Reset mid-frame: pipeline contents are discarded, no stat_valid pulse, frame_start=1.

Decomposition:
- Package abs_diff_pkg:
  - mode encodings MODE_ABS, MODE_BIN, MODE_PASS_A, MODE_PASS_B;
  - function abs_diff(a,b);
  - function sat_inc(count, increment).
- One sub-module, abs_diff_lane: one symbol's difference, mode select and compare flag, instantiated SYMBOLS_PER_BEAT times by generate.
- Pipeline, counters and control FSM (states IDLE/PENDING) stay in the top.

Test Plan:
- Mode 0, PIPE_STAGES=2, A=0x10_80_FF, B=0xF0_80_00, no stalls -> data_out=0xE0_00_FF two cycles after read.
- Mode 1, threshold=0x20, A=0x50_50_50, B=0x40_10_50 -> data_out=0x00_FF_00; chg_cnt increments by 1.
- 4-beat frame, every beat with 3 changed symbols, eop on beat 4 -> stat_beats=4, stat_changed=12, stat_valid one pulse; counters read 0 on the next cycle.
- vip_ctrl_valid_in with width=640 while 2 beats are in flight -> read=0; vip_ctrl_valid_out fires only after the second write, with width_out=640.
- stall_out held high for 5 cycles mid-frame -> write=0, data_out held, no beats lost or duplicated; order preserved (scoreboard).
- mode switched from 0 to 2 on beat 2 of a frame -> whole frame stays in mode 0; the next frame uses pass-A. rst=0 mid-frame -> all outputs 0, no stat_valid.
